clkdiv_ratio_detect: RTL

CLKDIV_RATIO_DETECT -- requirements
Module: clkdiv_ratio_detect

---
 rtl/clkdiv_pkg.sv | 25 ++
 rtl/clkdiv_sync_2ff.sv | 25 ++
 rtl/clkdiv_ratio_detect.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the divided-clock ratio detector.
// Holds the FSM state encoding, length limits and the length-to-code map.
package clkdiv_pkg;

  localparam int MAX_LEN = 8;
  localparam int CODE_W  = 3;
  localparam int LEN_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_MEASURE,
    ST_LOCKED
  } state_t;

  // A half-period of L clkin cycles corresponds to division code L-1.
  function automatic logic [CODE_W-1:0] len2code(
    input logic [LEN_W-1:0] len
  );
    logic [LEN_W-1:0] t;
    t = len - 4'd1;
    return t[CODE_W-1:0];
  endfunction

endpackage

// File: rtl/clkdiv_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports: i_clk, i_rstn (async, active-low), i_d (async in), o_q (synced out).
module sync_2ff (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/clkdiv_ratio_detect.sv
// Recovers the division code of an even 50%-duty divided clock by
// measuring its half-period in clkin cycles and locking on repeats.
// Ports: clkin, rstn (async, active-low), clkdiv_in (measured clock),
//   enable (run level), divbyvalue_out (code d), locked (code valid),
//   ratio_err (1-cycle pulse on bad measurement), loss (no edges).
module clkdiv_ratio_detect
  import clkdiv_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              clkdiv_in,
  input  logic              enable,
  output logic [CODE_W-1:0] divbyvalue_out,
  output logic              locked,
  output logic              ratio_err,
  output logic              loss
);

  localparam int RL_W = 6;
  localparam logic [RL_W-1:0]  TMO = RL_W'(TIMEOUT);
  localparam logic [LEN_W-1:0] LCK = LEN_W'(LOCK_COUNT);
  localparam logic [RL_W-1:0]  MXL = RL_W'(MAX_LEN);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_hist;
  logic [RL_W-1:0]   r_run_len;
  logic [RL_W-1:0]   w_run_len_nxt;
  logic [LEN_W-1:0]  r_cand;
  logic [LEN_W-1:0]  w_cand_nxt;
  logic [LEN_W-1:0]  r_match;
  logic [LEN_W-1:0]  w_match_nxt;
  logic [LEN_W-1:0]  w_match_inc;
  logic [CODE_W-1:0] r_div;
  logic [CODE_W-1:0] w_div_nxt;
  logic              r_locked;
  logic              w_locked_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              r_loss;
  logic              w_loss_nxt;

  logic              w_s2;
  logic              w_edge;
  logic              w_tmo;
  logic              w_len_ok;
  logic [LEN_W-1:0]  w_len;

  sync_2ff u_sync (
    .i_clk  (clkin),
    .i_rstn (rstn),
    .i_d    (clkdiv_in),
    .o_q    (w_s2)
  );

  // History tracks the synced level every cycle, so the level is
  // already current when IDLE hands over to SYNC.
  assign w_edge      = w_s2 ^ r_hist;
  assign w_tmo       = (r_run_len == TMO);
  assign w_len_ok    = (r_run_len != '0) && (r_run_len <= MXL);
  assign w_len       = r_run_len[LEN_W-1:0];
  assign w_match_inc = r_match + 4'd1;

  always_comb begin
    w_run_len_nxt = r_run_len;
    if (!enable || (r_state == ST_IDLE)) begin
      w_run_len_nxt = '0;
    end else if (w_edge) begin
      w_run_len_nxt = 6'd1;
    end else if (!w_tmo) begin
      w_run_len_nxt = r_run_len + 6'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_match_nxt  = r_match;
    w_div_nxt    = r_div;
    w_locked_nxt = r_locked;
    w_loss_nxt   = r_loss;
    w_err_nxt    = 1'b0;
    if (!enable) begin
      w_state_nxt  = ST_IDLE;
      w_locked_nxt = 1'b0;
      w_loss_nxt   = 1'b0;
      w_cand_nxt   = '0;
      w_match_nxt  = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt  = ST_SYNC;
          w_locked_nxt = 1'b0;
        end
        ST_SYNC: begin
          // First edge ends a partial period: discard it.
          if (w_edge) begin
            w_state_nxt = ST_MEASURE;
            w_cand_nxt  = '0;
            w_match_nxt = '0;
            w_loss_nxt  = 1'b0;
          end else if (w_tmo) begin
            w_loss_nxt   = 1'b1;
            w_locked_nxt = 1'b0;
          end
        end
        ST_MEASURE: begin
          if (w_edge) begin
            if (!w_len_ok) begin
              w_err_nxt   = 1'b1;
              w_cand_nxt  = '0;
              w_match_nxt = '0;
            end else if (w_len == r_cand) begin
              w_match_nxt = w_match_inc;
              if (w_match_inc == LCK) begin
                w_state_nxt  = ST_LOCKED;
                w_div_nxt    = len2code(r_cand);
                w_locked_nxt = 1'b1;
              end
            end else begin
              w_cand_nxt  = w_len;
              w_match_nxt = 4'd1;
            end
          end else if (w_tmo) begin
            w_state_nxt  = ST_SYNC;
            w_loss_nxt   = 1'b1;
            w_locked_nxt = 1'b0;
          end
        end
        ST_LOCKED: begin
          if (w_edge) begin
            if (!w_len_ok) begin
              w_err_nxt    = 1'b1;
              w_locked_nxt = 1'b0;
              w_cand_nxt   = '0;
              w_match_nxt  = '0;
              w_state_nxt  = ST_MEASURE;
            end else if (w_len != r_cand) begin
              w_err_nxt    = 1'b1;
              w_locked_nxt = 1'b0;
              w_cand_nxt   = w_len;
              w_match_nxt  = 4'd1;
              w_state_nxt  = ST_MEASURE;
            end
          end else if (w_tmo) begin
            w_state_nxt  = ST_SYNC;
            w_loss_nxt   = 1'b1;
            w_locked_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
    // Edges are at least one cycle apart and a bad measurement always
    // leaves LOCKED, but keep the pulse strictly single-cycle anyway.
    w_err_nxt = w_err_nxt & ~r_err;
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_hist    <= 1'b0;
      r_run_len <= '0;
      r_cand    <= '0;
      r_match   <= '0;
      r_div     <= '0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_loss    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hist    <= w_s2;
      r_run_len <= w_run_len_nxt;
      r_cand    <= w_cand_nxt;
      r_match   <= w_match_nxt;
      r_div     <= w_div_nxt;
      r_locked  <= w_locked_nxt;
      r_err     <= w_err_nxt;
      r_loss    <= w_loss_nxt;
    end
  end

  assign divbyvalue_out = r_div;
  assign locked         = r_locked;
  assign ratio_err      = r_err;
  assign loss           = r_loss;

endmodule
